// File: rtl/maxterm_table_sweeper.sv
// Streams the full truth table of an NVARS-input function given as a maxterm or
// minterm mask, one row per valid/ready transfer, then reports how many rows are 1.
module maxterm_table_sweeper #(
    parameter int NVARS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      mode,
    input  logic [(1<<NVARS)-1:0]     mask,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NVARS-1:0]          row,
    output logic                      value,
    output logic                      last,
    output logic                      busy,
    output logic                      done,
    output logic [NVARS:0]            ones
);

    localparam logic [NVARS-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NVARS-1:0]        index_q, index_d;
    logic [(1<<NVARS)-1:0]   mask_q, mask_d;
    logic                    mode_q, mode_d;
    logic [NVARS:0]          count_q, count_d;
    logic [NVARS:0]          ones_q, ones_d;

    logic cur_bit;
    logic cur_value;
    logic cur_last;

    // A set mask bit marks a 0 row in maxterm mode and a 1 row in minterm mode.
    assign cur_bit   = mask_q[index_q];
    assign cur_value = mode_q ? cur_bit : ~cur_bit;
    assign cur_last  = (index_q == LAST_IDX);
    assign ones      = ones_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            ones_q  <= ones_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        mask_d    = mask_q;
        mode_d    = mode_q;
        count_d   = count_q;
        ones_d    = ones_q;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        row       = '0;
        value     = 1'b0;
        last      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = mask;
                    mode_d  = mode;
                    index_d = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                row       = index_q;
                value     = cur_value;
                last      = cur_last;
                // Without out_ready the row is simply re-presented next cycle.
                if (out_ready) begin
                    count_d = count_q + {{NVARS{1'b0}}, cur_value};
                    if (cur_last) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                ones_d  = count_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_maxterm_table_sweeper.sv
// Scoreboard bench for maxterm_table_sweeper: an NVARS=3 and an NVARS=4 instance
// share clock, reset and stimulus; each sweep's expected rows are queued at start.
module tb_maxterm_table_sweeper;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        out_ready;
    logic        start3, start4;
    logic [15:0] mask;
    logic [7:0]  mask3;

    logic        v3, val3, last3, busy3, done3;
    logic [2:0]  row3;
    logic [3:0]  ones3;
    logic        v4, val4, last4, busy4, done4;
    logic [3:0]  row4;
    logic [4:0]  ones4;

    int          sel;
    logic        cv, cval, clast, cbusy, cdone;
    logic [3:0]  crow;
    logic [4:0]  cones;

    int          errors = 0;
    int          checks = 0;
    logic [4:0]  prev_ones3 = '0;
    logic [4:0]  prev_ones4 = '0;

    typedef struct {
        logic [3:0] row;
        logic       value;
        logic       last;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    assign mask3 = mask[7:0];
    assign cv    = (sel == 3) ? v3    : v4;
    assign cval  = (sel == 3) ? val3  : val4;
    assign clast = (sel == 3) ? last3 : last4;
    assign cbusy = (sel == 3) ? busy3 : busy4;
    assign cdone = (sel == 3) ? done3 : done4;
    assign crow  = (sel == 3) ? {1'b0, row3}  : row4;
    assign cones = (sel == 3) ? {1'b0, ones3} : ones4;

    maxterm_table_sweeper #(.NVARS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .mode(mode), .mask(mask3),
        .out_valid(v3), .out_ready(out_ready), .row(row3), .value(val3),
        .last(last3), .busy(busy3), .done(done3), .ones(ones3)
    );

    maxterm_table_sweeper #(.NVARS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode), .mask(mask),
        .out_valid(v4), .out_ready(out_ready), .row(row4), .value(val4),
        .last(last4), .busy(busy4), .done(done4), .ones(ones4)
    );

    // Full sweep on instance s; optional stall at one row and an ignored start
    // pulse (with mask/mode scrambled) at another row.
    task automatic run_sweep(input int s, input logic [15:0] m, input logic md,
                             input int stall_row, input int stall_cycles,
                             input int pulse_row, input string name);
        int         table_n;
        int         n_ones;
        int         stall_left;
        int         cyc;
        bit         pulsed;
        exp_t       e;
        logic [4:0] prev;
        logic [4:0] exp_ones;
        table_n    = (s == 3) ? 8 : 16;
        n_ones     = 0;
        stall_left = stall_cycles;
        pulsed     = 1'b0;
        sel        = s;
        mask       = m;
        mode       = md;
        out_ready  = 1'b1;
        q.delete();
        for (int i = 0; i < table_n; i++) begin
            e.row   = i[3:0];
            e.value = md ? m[i] : ~m[i];
            e.last  = (i == table_n - 1);
            if (e.value) n_ones++;
            q.push_back(e);
        end
        exp_ones = 5'(n_ones);
        prev = (s == 3) ? prev_ones3 : prev_ones4;
        if (s == 3) start3 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        start4 = 1'b0;
        cyc = 1;
        while (q.size() > 0 && cyc < 200) begin
            checks++;
            if (cv !== 1'b1 || cbusy !== 1'b1 || cdone !== 1'b0) begin
                errors++;
                $display("FAIL %s run_flags cyc=%0d: valid/busy/done=%b%b%b required 110",
                         name, cyc, cv, cbusy, cdone);
            end
            checks++;
            if (crow !== q[0].row || cval !== q[0].value || clast !== q[0].last) begin
                errors++;
                $display("FAIL %s row_data cyc=%0d: row=%0d value=%b last=%b required row=%0d value=%b last=%b",
                         name, cyc, crow, cval, clast, q[0].row, q[0].value, q[0].last);
            end
            checks++;
            if (cones !== prev) begin
                errors++;
                $display("FAIL %s ones_hold cyc=%0d: ones=%0d required %0d", name, cyc, cones, prev);
            end
            out_ready = 1'b1;
            if (int'(crow) == stall_row && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            if (!pulsed && int'(crow) == pulse_row) begin
                pulsed = 1'b1;
                if (s == 3) start3 = 1'b1; else start4 = 1'b1;
                mask = ~m;
                mode = ~md;
            end
            @(posedge clk); #1;
            start3 = 1'b0;
            start4 = 1'b0;
            if (out_ready) void'(q.pop_front());
            cyc++;
        end
        out_ready = 1'b1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d rows outstanding required 0", name, q.size());
        end
        checks++;
        if (cdone !== 1'b1 || cv !== 1'b0 || cbusy !== 1'b0 || cones !== prev) begin
            errors++;
            $display("FAIL %s done_cycle: done/valid/busy=%b%b%b ones=%0d required 100 ones=%0d",
                     name, cdone, cv, cbusy, cones, prev);
        end
        if (stall_cycles == 0) begin
            checks++;
            if (cyc != table_n + 1) begin
                errors++;
                $display("FAIL %s done_latency: cycle %0d required %0d", name, cyc, table_n + 1);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (cdone !== 1'b0 || cv !== 1'b0 || cones !== exp_ones) begin
            errors++;
            $display("FAIL %s final: done=%b valid=%b ones=%0d required done=0 valid=0 ones=%0d",
                     name, cdone, cv, cones, exp_ones);
        end
        if (s == 3) prev_ones3 = exp_ones; else prev_ones4 = exp_ones;
        $display("sweep %s: NVARS=%0d mask=%h mode=%b ones=%0d", name, s, m, md, cones);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start3    = 1'b0;
        start4    = 1'b0;
        mode      = 1'b0;
        mask      = '0;
        out_ready = 1'b1;
        sel       = 4;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({v4, busy4, done4, last4, val4, row4, ones4} !== 14'd0 ||
            {v3, busy3, done3, last3, val3, row3, ones3} !== 12'd0) begin
            errors++;
            $display("FAIL reset_state: dut4=%b dut3=%b required all zero",
                     {v4, busy4, done4, last4, val4, row4, ones4},
                     {v3, busy3, done3, last3, val3, row3, ones3});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (v4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b busy=%b required 0 0", v4, busy4);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int guard;
        sel       = 4;
        mask      = 16'h00FF;
        mode      = 1'b1;
        out_ready = 1'b1;
        start4    = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        guard  = 0;
        while (row4 !== 4'd6 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (row4 !== 4'd6 || v4 !== 1'b1) begin
            errors++;
            $display("FAIL reach_row6: row=%0d valid=%b required row=6 valid=1", row4, v4);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (v4 !== 1'b0 || busy4 !== 1'b0 || ones4 !== 5'd0 || row4 !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b ones=%0d row=%0d required 0 0 0 0",
                     v4, busy4, ones4, row4);
        end
        prev_ones3 = '0;
        prev_ones4 = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run_sweep(4, 16'h1957, 1'b0, -1, 0, -1, "after_reset");
    endtask

    initial begin
        test_reset();
        run_sweep(3, 16'h00C6, 1'b0, -1, 0, -1, "n3_c6_maxterm");
        run_sweep(4, 16'h1957, 1'b0, -1, 0, -1, "n4_1957_maxterm");
        run_sweep(4, 16'h1957, 1'b1, -1, 0, -1, "n4_1957_minterm");
        run_sweep(4, 16'h8396, 1'b0, 5, 3, -1, "stall_row5");
        run_sweep(4, 16'h0000, 1'b1, -1, 0, -1, "zero_minterm");
        run_sweep(4, 16'h0000, 1'b0, -1, 0, -1, "zero_maxterm");
        run_sweep(4, 16'hA5C3, 1'b0, -1, 0, 3, "start_ignored");
        run_sweep(3, 16'h0000, 1'b0, 2, 2, -1, "n3_all_ones");
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
